// File: rtl/vc_buffer.sv
// Multi-VC input buffer: NUM_VC independent show-ahead queues of DEPTH entries
// sharing one storage array, with per-VC occupancy, credit and sticky error flags.
module vc_buffer #(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 64,
    parameter int NUM_VC    = 4,
    parameter int AF_THRESH = DEPTH - 2,
    localparam int VCW      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in,
    input  logic [VCW-1:0]       in_vc,
    input  logic                 produce,
    input  logic [VCW-1:0]       out_vc,
    input  logic                 consume,
    output logic [WIDTH-1:0]     out,
    output logic [NUM_VC-1:0]    empty,
    output logic [NUM_VC-1:0]    full,
    output logic [NUM_VC-1:0]    almost_full,
    output logic [NUM_VC*CW-1:0] usedw,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int AW = (NUM_VC * DEPTH > 1) ? $clog2(NUM_VC * DEPTH) : 1;
    localparam logic [VCW:0] VC_LIMIT = (VCW + 1)'(NUM_VC);

    logic [WIDTH-1:0] mem   [NUM_VC*DEPTH];
    logic [PW-1:0]    head  [NUM_VC];
    logic [PW-1:0]    tail  [NUM_VC];
    logic [CW-1:0]    count [NUM_VC];

    logic             wr_range;
    logic             rd_range;
    logic [VCW-1:0]   wr_vc;
    logic [VCW-1:0]   rd_vc;
    logic             wr_ok;
    logic             rd_ok;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic [NUM_VC-1:0] wr_hit;
    logic [NUM_VC-1:0] rd_hit;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Status is a pure function of the registered counts, so flags only move at edges.
    always_comb begin
        empty       = '0;
        full        = '0;
        almost_full = '0;
        usedw       = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            empty[v]           = (count[v] == '0);
            full[v]            = (count[v] == CW'(DEPTH));
            almost_full[v]     = (count[v] >= CW'(AF_THRESH));
            usedw[v*CW +: CW]  = count[v];
        end
    end

    // produce/consume are requests with no back-pressure: a request is accepted
    // when the addressed VC is in range and has room (write) or data (pop), judged
    // on pre-edge state; a refused request is dropped and sets its sticky flag.
    always_comb begin
        wr_range = ({1'b0, in_vc} < VC_LIMIT);
        rd_range = ({1'b0, out_vc} < VC_LIMIT);
        wr_vc    = wr_range ? in_vc : '0;
        rd_vc    = rd_range ? out_vc : '0;
        wr_ok    = produce && wr_range && !full[wr_vc];
        rd_ok    = consume && rd_range && !empty[rd_vc];
        wr_addr  = AW'(wr_vc) * AW'(DEPTH) + AW'(tail[wr_vc]);
        rd_addr  = AW'(rd_vc) * AW'(DEPTH) + AW'(head[rd_vc]);
        wr_hit   = '0;
        rd_hit   = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            wr_hit[v] = wr_ok && (wr_vc == VCW'(v));
            rd_hit[v] = rd_ok && (rd_vc == VCW'(v));
        end
    end

    always_comb begin
        out = '0;
        if (rd_range && !empty[rd_vc]) begin
            out = mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                head[v]  <= '0;
                tail[v]  <= '0;
                count[v] <= '0;
            end
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (wr_hit[v]) begin
                    tail[v] <= bump(tail[v]);
                end
                if (rd_hit[v]) begin
                    head[v] <= bump(head[v]);
                end
                // A simultaneous accepted write and pop on one VC leaves its count unchanged.
                if (wr_hit[v] && !rd_hit[v]) begin
                    count[v] <= count[v] + CW'(1);
                end else if (rd_hit[v] && !wr_hit[v]) begin
                    count[v] <= count[v] - CW'(1);
                end
            end
            if (produce && !wr_ok) begin
                overflow <= 1'b1;
            end
            if (consume && !rd_ok) begin
                underflow <= 1'b1;
            end
        end
    end

    // Storage carries no reset; stale words are never visible because out is gated by count.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wr_addr] <= in;
        end
    end

endmodule

// File: doc/vc_buffer.md
# vc_buffer

Multi-channel, parametrised FIFO for router input ports. It holds `NUM_VC` independent virtual-channel queues of `DEPTH` entries each, and all `DEPTH` slots are usable. It reports exact per-VC occupancy and an almost-full credit signal, and latches sticky overflow and underflow error flags. It sits between the link receiver (write side) and the router's VC allocator / crossbar (read side), in place of single-queue buffers.

## Interface
Parameters:
- `DEPTH`, 8: entries per VC. Any integer ≥ 2; powers of two are not required.
- `WIDTH`, 64: flit width in bits.
- `NUM_VC`, 4: number of virtual channels, ≥ 1.
- `AF_THRESH`, `DEPTH-2`: `almost_full[v]` asserts when the count of VC v is ≥ this value. Legal range is 1..`DEPTH`.
- Derived: `VCW` = max(1, clog2(`NUM_VC`)); `CW` = clog2(`DEPTH`+1).

Ports:
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `in`, in, `WIDTH`: write data.
- `in_vc`, in, `VCW`: target VC of the write.
- `produce`, in, 1: write request.
- `out_vc`, in, `VCW`: VC selected for read and for the `out` view.
- `consume`, in, 1: pop request for `out_vc`.
- `out`, out, `WIDTH`: head entry of `out_vc` (show-ahead, combinational).
- `empty`, out, `NUM_VC`: per-VC empty, bit v corresponds to VC v.
- `full`, out, `NUM_VC`: per-VC full.
- `almost_full`, out, `NUM_VC`: per-VC count ≥ `AF_THRESH`.
- `usedw`, out, `NUM_VC*CW`: per-VC count. Bits [v*CW +: CW] hold VC v's count, range 0..`DEPTH`.
- `overflow`, out, 1: sticky. Set when a write is dropped.
- `underflow`, out, 1: sticky. Set when a pop is ignored.

## Operation
Per-VC state:
- head pointer, tail pointer, and count.
- Pointers wrap from `DEPTH-1` to 0.
- Storage is `NUM_VC*DEPTH` words and is not reset.

Status outputs (all combinational from registered state only):
- `empty[v]` = (count == 0).
- `full[v]` = (count == `DEPTH`).
- `almost_full[v]` = (count ≥ `AF_THRESH`).
- `usedw` slice v = count.

Write rules:
- A write is accepted when `produce` is high, `in_vc` < `NUM_VC`, and `full[in_vc]` is low.
- On accept: `in` is stored at the tail of VC `in_vc`, the tail advances, and the count increments.
- Otherwise, if `produce` is high, the write is dropped and `overflow` is set. This covers both a full target and an out-of-range `in_vc`.

Pop rules:
- A pop is accepted when `consume` is high, `out_vc` < `NUM_VC`, and `empty[out_vc]` is low.
- On accept: the head of VC `out_vc` advances and the count decrements.
- Otherwise, if `consume` is high, nothing changes and `underflow` is set.

Output data:
- `out` = storage[`out_vc`][head] when `empty[out_vc]` is low.
- `out` = 0 when that VC is empty or `out_vc` is out of range.

Acceptance and counts:
- Acceptance is decided on pre-edge state only. Flags do not bypass.
- Same VC, count == `DEPTH`, produce and consume together: the pop is accepted, the write is dropped, `overflow` is set, and the count becomes `DEPTH`-1.
- Same VC, count == 0, produce and consume together: the write is accepted, the pop is ignored, `underflow` is set, and the count becomes 1.
- Same VC, 0 < count < `DEPTH`, both accepted: the count is unchanged and both pointers advance.
- Different VCs: write and pop proceed independently in the same cycle.

Reset:
- `rst` overrides everything in the same edge.
- After reset: all pointers and counts are 0, `empty` is all-ones, `full` and `almost_full` are all-zeros, `usedw` is 0, `overflow` and `underflow` are 0, and `out` is 0.
- A reset mid-operation discards all queued data.
- The sticky flags are cleared only by `rst`.

## Timing
- Write-to-read latency is 1 cycle: data written at edge N is visible on `out` (if it is at the head) and counted in `usedw` after edge N.
- The pop takes effect at the edge. The next entry appears on `out` in the cycle following the edge.
- `out` follows `out_vc` changes combinationally within the same cycle.
- Status flags change only at edges.
- `almost_full` is registered-state based. Upstream senders use it as a credit stop with at least `DEPTH-AF_THRESH` cycles of slack.
- Throughput: one write and one pop per cycle, sustained, with no bubbles.

## Test plan
- Reset, then idle: `empty`=4'b1111, `full`=0, `usedw`=0, `out`=0, both error flags 0.
- Fill VC2 with 8 writes of values 0x10..0x17: after the 8th edge, `full[2]`=1, `usedw[2]`=8, `almost_full[2]` set from the 6th write onward, and other VCs stay empty. A 9th write sets `overflow` and `usedw[2]` stays 8. Popping 8 times with `out_vc`=2 yields 0x10..0x17 in order.
- Wrap-around with `DEPTH`=6 (non-power-of-two): perform 20 interleaved write/pop pairs on VC0. Data order is preserved, and `usedw[0]` is constant at the preload level throughout.
- Simultaneous events on the same VC:
  - At count 8 (full): produce and consume together give count 7 and `overflow`=1.
  - At count 0 (empty): produce and consume together give count 1 and `underflow`=1, and the written value appears on `out` the next cycle.
- Cross-VC concurrency: for 16 cycles, write VC1 while popping VC3 (VC3 preloaded with 4 entries). VC3 drains to 0, VC1 reaches 8 and then drops writes, and VC0/VC2 counts stay 0.
- Reset mid-operation with 5 entries in VC1 and `overflow`=1: after the `rst` edge, all counts are 0, `overflow`=0, and `out`=0.
